// File: rtl/timer_ctrl_unit.sv
// timer_ctrl_unit: configuration registers and sequencing for a general-purpose up-counting timer.
//
// Holds CR/PSC/ARR/SR (and optionally CCR) with preload and active (shadow) copies. It runs a
// prescaler and an up-counter, and raises a sticky update flag with an interrupt output.
//
// Optional feature: define TIM_CMP_EN to add the CCR compare register, pwm_out and SR.CCIF.
//
// Ports:
//   clk        system clock, all logic on posedge
//   reset      synchronous active-high reset
//   cfg_valid  config access request; cfg_we selects write (1) or read (0)
//   cfg_addr   0 CR, 1 PSC, 2 ARR, 3 SR, 4 CNT, 5 CCR
//   cfg_wdata  write data
//   cfg_ready  access accepted this cycle (low the cycle after an accepted read)
//   cfg_rvalid read data valid, one cycle after an accepted read
//   cfg_rdata  read data
//   tim_cnt    current counter value
//   tim_run    CR.CEN
//   upd_pulse  one-cycle pulse following an update event
//   tim_irq    SR.UIF & CR.UIE
//   pwm_out    compare output (tied 0 without TIM_CMP_EN)
module timer_ctrl_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_wdata,
  output logic             cfg_ready,
  output logic             cfg_rvalid,
  output logic [CNT_W-1:0] cfg_rdata,
  output logic [CNT_W-1:0] tim_cnt,
  output logic             tim_run,
  output logic             upd_pulse,
  output logic             tim_irq,
  output logic             pwm_out
);

  typedef enum logic [1:0] {StIdle, StArm, StRun} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cr_q, cr_d;        // [0] CEN [1] OPM [2] ARPE [3] UIE
  logic [1:0]       sr_q, sr_d;        // [0] UIF [1] CCIF
  logic [CNT_W-1:0] psc_pre_q, psc_pre_d, psc_act_q, psc_act_d;
  logic [CNT_W-1:0] arr_pre_q, arr_pre_d, arr_act_q, arr_act_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, psc_cnt_q, psc_cnt_d;
  logic [CNT_W-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             upd_q, upd_d;
  logic             acc, wr, rd, tick, upd_evt;
`ifdef TIM_CMP_EN
  logic [CNT_W-1:0] ccr_pre_q, ccr_pre_d, ccr_act_q, ccr_act_d;
`endif

  // The read pipeline is single-entry, so no access is taken while read data is pending.
  assign acc = cfg_valid & ~rvalid_q;
  assign wr  = acc & cfg_we;
  assign rd  = acc & ~cfg_we;

  always_comb begin
    state_d   = state_q;
    cr_d      = cr_q;
    sr_d      = sr_q;
    psc_pre_d = psc_pre_q;
    psc_act_d = psc_act_q;
    arr_pre_d = arr_pre_q;
    arr_act_d = arr_act_q;
    cnt_d     = cnt_q;
    psc_cnt_d = psc_cnt_q;
    rdata_d   = '0;
    rvalid_d  = rd;
    upd_d     = 1'b0;
    tick      = 1'b0;
    upd_evt   = 1'b0;
`ifdef TIM_CMP_EN
    ccr_pre_d = ccr_pre_q;
    ccr_act_d = ccr_act_q;
`endif

    // Write-1-to-clear first so that a hardware set in the same cycle wins.
    if (wr && cfg_addr == 3'd3) sr_d = sr_q & ~cfg_wdata[1:0];

    unique case (state_q)
      StIdle: if (cr_q[0]) state_d = StArm;
      StArm: begin
        psc_act_d = psc_pre_q;
        arr_act_d = arr_pre_q;
`ifdef TIM_CMP_EN
        ccr_act_d = ccr_pre_q;
`endif
        psc_cnt_d = '0;
        state_d   = StRun;
      end
      StRun: begin
        if (!cr_q[0]) begin
          state_d = StIdle;
        end else begin
          if (psc_cnt_q == psc_act_q) begin
            psc_cnt_d = '0;
            tick      = 1'b1;
          end else begin
            psc_cnt_d = psc_cnt_q + CNT_W'(1);
          end
          if (tick) begin
            // >= keeps the period bounded if ARR is lowered below cnt without preload.
            if (cnt_q >= arr_act_q) begin
              cnt_d   = '0;
              upd_evt = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
`ifdef TIM_CMP_EN
            if (cnt_d == ccr_act_q) sr_d[1] = 1'b1;
`endif
          end
          if (upd_evt) begin
            upd_d     = 1'b1;
            sr_d[0]   = 1'b1;
            psc_act_d = psc_pre_q;
            arr_act_d = arr_pre_q;
`ifdef TIM_CMP_EN
            ccr_act_d = ccr_pre_q;
`endif
            if (cr_q[1]) begin
              cr_d[0] = 1'b0;
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Register writes are applied last: a CNT write beats a tick, a direct ARR write beats reload.
    if (wr) begin
      unique case (cfg_addr)
        3'd0: cr_d = cfg_wdata[3:0];
        3'd1: psc_pre_d = cfg_wdata;
        3'd2: begin
          arr_pre_d = cfg_wdata;
          if (!cr_q[2]) arr_act_d = cfg_wdata;
        end
        3'd4: begin
          cnt_d     = cfg_wdata;
          psc_cnt_d = '0;
        end
`ifdef TIM_CMP_EN
        3'd5: ccr_pre_d = cfg_wdata;
`endif
        default: ;
      endcase
    end

    if (rd) begin
      unique case (cfg_addr)
        3'd0: rdata_d = CNT_W'(cr_q);
        3'd1: rdata_d = psc_pre_q;
        3'd2: rdata_d = arr_pre_q;
        3'd3: rdata_d = CNT_W'(sr_q);
        3'd4: rdata_d = cnt_q;
`ifdef TIM_CMP_EN
        3'd5: rdata_d = ccr_pre_q;
`endif
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cr_q      <= '0;
      sr_q      <= '0;
      psc_pre_q <= '0;
      psc_act_q <= '0;
      arr_pre_q <= '0;
      arr_act_q <= '0;
      cnt_q     <= '0;
      psc_cnt_q <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      upd_q     <= 1'b0;
`ifdef TIM_CMP_EN
      ccr_pre_q <= '0;
      ccr_act_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cr_q      <= cr_d;
      sr_q      <= sr_d;
      psc_pre_q <= psc_pre_d;
      psc_act_q <= psc_act_d;
      arr_pre_q <= arr_pre_d;
      arr_act_q <= arr_act_d;
      cnt_q     <= cnt_d;
      psc_cnt_q <= psc_cnt_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      upd_q     <= upd_d;
`ifdef TIM_CMP_EN
      ccr_pre_q <= ccr_pre_d;
      ccr_act_q <= ccr_act_d;
`endif
    end
  end

  assign cfg_ready  = ~rvalid_q;
  assign cfg_rvalid = rvalid_q;
  assign cfg_rdata  = rdata_q;
  assign tim_cnt    = cnt_q;
  assign tim_run    = cr_q[0];
  assign upd_pulse  = upd_q;
  assign tim_irq    = sr_q[0] & cr_q[3];
`ifdef TIM_CMP_EN
  assign pwm_out    = (state_q == StRun) && (cnt_q < ccr_act_q);
`else
  assign pwm_out    = 1'b0;
`endif

endmodule

// File: tb/tb_timer_ctrl_unit.sv
// Self-checking bench for timer_ctrl_unit: directed scenarios plus randomized PSC/ARR runs
// checked against closed-form period arithmetic.
module tb_timer_ctrl_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [15:0] cfg_wdata = '0;
  logic        cfg_ready, cfg_rvalid, tim_run, upd_pulse, tim_irq, pwm_out;
  logic [15:0] cfg_rdata, tim_cnt;

  int vectors = 0;
  int miscompares = 0;

  timer_ctrl_unit #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_ready(cfg_ready), .cfg_rvalid(cfg_rvalid), .cfg_rdata(cfg_rdata),
    .tim_cnt(tim_cnt), .tim_run(tim_run), .upd_pulse(upd_pulse), .tim_irq(tim_irq),
    .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // Advance to 1 time unit after the next rising edge (inputs driven and outputs sampled here).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    cfg_valid = 1'b1; cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_valid = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Returns in the first RUN cycle: CR write edge, then IDLE->ARM, then ARM->RUN.
  task automatic start(input int psc, input int arr, input int cr);
    wr(3'd1, 16'(psc));
    wr(3'd2, 16'(arr));
    wr(3'd0, 16'(cr));
    step();
    step();
  endtask

  task automatic test_reset();
    logic [6:0] got;
    do_reset();
    got = {tim_cnt != 0, tim_run, upd_pulse, tim_irq, pwm_out, cfg_rvalid, ~cfg_ready};
    vectors++;
    if (got !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_state got %b exp 0000000", got);
    end
  endtask

  task automatic test_basic();
    do_reset();
    start(1, 3, 9);
    for (int k = 0; k <= 8; k++) begin
      vectors++;
      if (tim_cnt !== 16'((k / 2) % 4)) begin
        miscompares++;
        $display("FAIL basic_cnt k=%0d got %0d exp %0d", k, tim_cnt, (k / 2) % 4);
      end
      vectors++;
      if (upd_pulse !== (k == 8)) begin
        miscompares++;
        $display("FAIL basic_upd k=%0d got %b exp %b", k, upd_pulse, k == 8);
      end
      vectors++;
      if (tim_irq !== (k == 8)) begin
        miscompares++;
        $display("FAIL basic_irq k=%0d got %b exp %b", k, tim_irq, k == 8);
      end
      step();
    end
  endtask

  task automatic test_opm();
    do_reset();
    start(0, 2, 3);
    for (int k = 0; k <= 6; k++) begin
      vectors++;
      if (tim_cnt !== 16'(k < 3 ? k : 0) || upd_pulse !== (k == 3) || tim_run !== (k < 3)) begin
        miscompares++;
        $display("FAIL opm k=%0d got cnt=%0d upd=%b run=%b exp cnt=%0d upd=%b run=%b", k,
                 tim_cnt, upd_pulse, tim_run, k < 3 ? k : 0, k == 3, k < 3);
      end
      step();
    end
  endtask

  task automatic test_arpe();
    int exp_cnt;
    // Preloaded: the running period still ends at 5, the following one at 2.
    do_reset();
    start(0, 5, 5);
    for (int k = 0; k <= 10; k++) begin
      exp_cnt = (k <= 5) ? k : (k - 6) % 3;
      vectors++;
      if (tim_cnt !== 16'(exp_cnt) || upd_pulse !== (k == 6 || k == 9)) begin
        miscompares++;
        $display("FAIL arpe1 k=%0d got cnt=%0d upd=%b exp cnt=%0d upd=%b", k, tim_cnt, upd_pulse,
                 exp_cnt, k == 6 || k == 9);
      end
      if (k == 2) begin
        cfg_valid = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd2; cfg_wdata = 16'd2;
      end
      step();
      cfg_valid = 1'b0; cfg_we = 1'b0;
    end
    // Direct: the new limit applies to the running period.
    do_reset();
    start(0, 5, 1);
    for (int k = 0; k <= 9; k++) begin
      exp_cnt = (k <= 2) ? k : (k - 3) % 3;
      vectors++;
      if (tim_cnt !== 16'(exp_cnt) || upd_pulse !== (k == 3 || k == 6 || k == 9)) begin
        miscompares++;
        $display("FAIL arpe0 k=%0d got cnt=%0d upd=%b exp cnt=%0d upd=%b", k, tim_cnt, upd_pulse,
                 exp_cnt, k == 3 || k == 6 || k == 9);
      end
      if (k == 1) begin
        cfg_valid = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd2; cfg_wdata = 16'd2;
      end
      step();
      cfg_valid = 1'b0; cfg_we = 1'b0;
    end
  endtask

  task automatic test_sr_clear();
    do_reset();
    start(0, 2, 9);
    for (int k = 0; k <= 6; k++) begin
      vectors++;
      if (tim_irq !== (k == 3 || k == 6)) begin
        miscompares++;
        $display("FAIL sr_clear_irq k=%0d got %b exp %b", k, tim_irq, k == 3 || k == 6);
      end
      // k==2 is the update-event cycle (set must win); k==3 is a plain clear.
      if (k == 2 || k == 3) begin
        cfg_valid = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd3; cfg_wdata = 16'd1;
      end
      step();
      cfg_valid = 1'b0; cfg_we = 1'b0;
    end
  endtask

  task automatic test_read_reset();
    do_reset();
    wr(3'd2, 16'd7);
    vectors++;
    if (cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL read_ready_before got %b exp 1", cfg_ready);
    end
    cfg_valid = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd2;
    step();
    cfg_valid = 1'b0;
    vectors++;
    if (cfg_ready !== 1'b0 || cfg_rvalid !== 1'b1 || cfg_rdata !== 16'd7) begin
      miscompares++;
      $display("FAIL read_arr got ready=%b rvalid=%b rdata=%0d exp ready=0 rvalid=1 rdata=7",
               cfg_ready, cfg_rvalid, cfg_rdata);
    end
    step();
    vectors++;
    if (cfg_ready !== 1'b1 || cfg_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL read_after got ready=%b rvalid=%b exp ready=1 rvalid=0", cfg_ready,
               cfg_rvalid);
    end
    start(0, 7, 9);
    for (int k = 0; k < 9; k++) step();
    vectors++;
    if (tim_cnt !== 16'd1 || tim_irq !== 1'b1 || tim_run !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset got cnt=%0d irq=%b run=%b exp cnt=1 irq=1 run=1", tim_cnt,
               tim_irq, tim_run);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++;
    if (tim_cnt !== 16'd0 || tim_irq || tim_run || upd_pulse || pwm_out || cfg_rvalid ||
        !cfg_ready) begin
      miscompares++;
      $display("FAIL mid_reset got cnt=%0d irq=%b run=%b upd=%b pwm=%b rvalid=%b ready=%b exp 0s",
               tim_cnt, tim_irq, tim_run, upd_pulse, pwm_out, cfg_rvalid, cfg_ready);
    end
  endtask

  task automatic test_cnt_write();
    do_reset();
    start(0, 9, 1);
    step(); step(); step();
    cfg_valid = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd4; cfg_wdata = 16'd7;
    step();
    cfg_valid = 1'b0; cfg_we = 1'b0;
    vectors++;
    if (tim_cnt !== 16'd7) begin
      miscompares++;
      $display("FAIL cnt_write got %0d exp 7", tim_cnt);
    end
    step();
    vectors++;
    if (tim_cnt !== 16'd8) begin
      miscompares++;
      $display("FAIL cnt_write_next got %0d exp 8", tim_cnt);
    end
  endtask

  task automatic test_compare();
    int high;
    high = 0;
    do_reset();
    wr(3'd5, 16'd4);
    start(0, 9, 1);
    for (int k = 0; k < 10; k++) begin
`ifdef TIM_CMP_EN
      vectors++;
      if (pwm_out !== (k < 4)) begin
        miscompares++;
        $display("FAIL pwm k=%0d got %b exp %b", k, pwm_out, k < 4);
      end
`else
      vectors++;
      if (pwm_out !== 1'b0) begin
        miscompares++;
        $display("FAIL pwm_off k=%0d got %b exp 0", k, pwm_out);
      end
`endif
      if (pwm_out === 1'b1) high++;
      step();
    end
    cfg_valid = 1'b1; cfg_we = 1'b0;
`ifdef TIM_CMP_EN
    cfg_addr = 3'd3;
`else
    cfg_addr = 3'd5;
`endif
    step();
    cfg_valid = 1'b0;
`ifdef TIM_CMP_EN
    vectors++;
    if (high != 4 || cfg_rdata[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL compare got high=%0d ccif=%b exp high=4 ccif=1", high, cfg_rdata[1]);
    end
`else
    vectors++;
    if (high != 0 || cfg_rdata !== 16'd0) begin
      miscompares++;
      $display("FAIL ccr_absent got high=%0d rdata=%0d exp high=0 rdata=0", high, cfg_rdata);
    end
`endif
  endtask

  task automatic test_random();
    int p, a, per;
    for (int it = 0; it < 6; it++) begin
      p = (it == 1) ? 0 : int'($urandom_range(0, 3));
      a = (it == 0) ? 0 : int'($urandom_range(0, 6));
      per = (p + 1) * (a + 1);
      do_reset();
      start(p, a, 9);
      for (int k = 0; k <= 2 * per + 1; k++) begin
        vectors++;
        if (tim_cnt !== 16'((k / (p + 1)) % (a + 1)) || upd_pulse !== (k > 0 && k % per == 0) ||
            tim_irq !== (k >= per)) begin
          miscompares++;
          $display("FAIL random psc=%0d arr=%0d k=%0d got cnt=%0d upd=%b irq=%b exp %0d %b %b",
                   p, a, k, tim_cnt, upd_pulse, tim_irq, (k / (p + 1)) % (a + 1),
                   k > 0 && k % per == 0, k >= per);
        end
        step();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_opm();
    test_arpe();
    test_sr_clear();
    test_read_reset();
    test_cnt_write();
    test_compare();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
